// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM encodings for the iterative mul/div unit.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: shift-add multiply step or
// restoring divide step on the WIDTH+1-bit partial register.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH:0]   i_part,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_part,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum  = i_part + {1'b0, i_m};
    w_add  = i_q[0] ? w_sum : i_part;
    w_sh   = {i_part[WIDTH-1:0], i_q[WIDTH-1]};
    w_diff = w_sh - {1'b0, i_m};
    o_part = {1'b0, w_add[WIDTH:1]};
    o_q    = {w_add[0], i_q[WIDTH-1:1]};
    if (i_div) begin
      // bit WIDTH of the trial difference is its sign
      if (!w_diff[WIDTH]) begin
        o_part = w_diff;
        o_q    = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_part = w_sh;
        o_q    = {i_q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Signed MULT/DIV enabled by defining MULDIV_SIGNED_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  md_state_e r_state;
  md_state_e w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_part;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div;
  logic             r_bz;
  logic             r_sa;
  logic             r_sb;
  logic             r_done;

  logic             w_sgn;
  logic             w_go;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic [WIDTH:0]   w_part;
  logic [WIDTH-1:0] w_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign busy = (r_state != MD_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    w_sgn = SGN_EN & ~op[0];
    w_go  = (r_state == MD_IDLE) & start & ~flush;
    w_ma  = (w_sgn & a[WIDTH-1]) ? -a : a;
    w_mb  = (w_sgn & b[WIDTH-1]) ? -b : b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_part (r_part),
    .i_q    (r_q),
    .i_m    (r_m),
    .o_part (w_part),
    .o_q    (w_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_go) w_state_nxt = MD_CALC;
      MD_CALC: begin
        if (flush)
          w_state_nxt = MD_IDLE;
        else if (r_cnt == CW'(1))
          w_state_nxt = MD_FIX;
      end
      MD_FIX:  w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_state_nxt;
  end

  // multiply works on |a|,|b|; divide keeps dividend in r_q, divisor in r_m
  always_ff @(posedge clk) begin
    if (w_go) begin
      r_cnt  <= CW'(WIDTH);
      r_part <= '0;
      r_div  <= op[1];
      r_a    <= a;
      r_bz   <= (b == '0);
      r_sa   <= w_sgn & a[WIDTH-1];
      r_sb   <= w_sgn & b[WIDTH-1];
      r_q    <= op[1] ? w_ma : w_mb;
      r_m    <= op[1] ? w_mb : w_ma;
    end else if (r_state == MD_CALC) begin
      r_cnt  <= r_cnt - CW'(1);
      r_part <= w_part;
      r_q    <= w_q;
    end
  end

  always_comb begin
    w_prod = {r_part[WIDTH-1:0], r_q};
    w_quot = r_q;
    w_rem  = r_part[WIDTH-1:0];
    if (r_sa ^ r_sb) begin
      w_prod = -w_prod;
      w_quot = -w_quot;
    end
    if (r_sa) w_rem = -w_rem;
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_div && r_bz) begin
      w_fix_hi = r_a;
      w_fix_lo = '1;
    end else if (r_div) begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == MD_FIX) & ~flush;
      if (!flush) begin
        if (r_state == MD_FIX) begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end else if (r_state == MD_IDLE) begin
          if (mthi) r_hi <= a;
          if (mtlo) r_lo <= a;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive start at a negedge; returns at the negedge of cycle 1
  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc, output int nb);
    cyc = c0;
    nb  = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    int nb;
    @(negedge clk);
    issue(o, x, y);
    wait_done(1, cyc, nb);
    check({tag, "_cyc"}, 64'(cyc), 64'd34);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int cyc;
    int nb;
    int cnt;
    rst_n = 1'b0;
    start = 1'b0;
    op    = MD_MULTU;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {30'd0, busy, done, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;

    // full-width unsigned multiply with cycle-accurate busy/done
    @(negedge clk);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc, nb);
    check("mulu_cyc", 64'(cyc), 64'd34);
    check("mulu_busy_n", 64'(nb), 64'd33);
    check("mulu_busy_done", {63'd0, busy}, 64'd0);
    check("mulu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    check("mulu_lo", {32'd0, lo}, 64'h1);
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd0);

`ifdef MULDIV_SIGNED_EN
    run("mult_n7x3", MD_MULT, -32'sd7, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("mult_7xn3", MD_MULT, 32'd7, -32'sd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("div_n7d2", MD_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_7dn2", MD_DIV, 32'd7, -32'sd2, 32'h1, 32'hFFFF_FFFD);
    run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,
        32'h8000_0000);
`else
    run("mult_nosgn", MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);
    run("div_nosgn", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC);
    run("div_big", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
        32'h0);
`endif
    run("div_n5z", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB,
        32'hFFFF_FFFF);
    run("divu_z", MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run("mulu_6x7", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    // start while busy is dropped, not queued
    @(negedge clk);
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    issue(MD_MULTU, 32'd3, 32'd3);
    wait_done(6, cyc, nb);
    check("ign_cyc", 64'(cyc), 64'd34);
    check("ign_hi", {32'd0, hi}, 64'd2);
    check("ign_lo", {32'd0, lo}, 64'd14);
    count_done(40, cnt);
    check("ign_noqueue", 64'(cnt), 64'd0);

    // flush in cycle 10
    issue(MD_DIVU, 32'd200, 32'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    count_done(40, cnt);
    check("flush_nodone", 64'(cnt), 64'd0);
    check("flush_hilo", {hi, lo}, {32'd2, 32'd14});

    // move-to writes
    mtlo = 1'b1;
    a    = 32'h1234;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", {hi, lo}, {32'd2, 32'h1234});
    mthi = 1'b1;
    mtlo = 1'b1;
    a    = 32'h55;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mthilo", {hi, lo}, {32'h55, 32'h55});

    issue(MD_MULTU, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    mthi = 1'b1;
    a    = 32'hDEAD;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_busy", {32'd0, hi}, 64'h55);
    wait_done(6, cyc, nb);
    check("mthi_busy_res", {hi, lo}, {32'd0, 32'd30});

    // move-to together with start: write lands, result overwrites
    @(negedge clk);
    mtlo = 1'b1;
    issue(MD_MULTU, 32'h77, 32'd2);
    mtlo = 1'b0;
    check("mtlo_start", {32'd0, lo}, 64'h77);
    wait_done(1, cyc, nb);
    check("mtlo_start_res", {hi, lo}, {32'd0, 32'hEE});

    // back-to-back issue in the done cycle
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(1, cyc, nb);
    check("b2b_cyc", 64'(cyc), 64'd34);
    check("b2b_res", {hi, lo}, {32'd2, 32'd14});

    // reset mid-operation
    @(negedge clk);
    issue(MD_MULT, 32'd9, 32'd9);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid", {30'd0, busy, done, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    run("post_rst", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the execute stage, the sequential companion to the single-cycle ALU. Computes MIPS-style MULT/MULTU/DIV/DIVU on WIDTH-bit operands, one result bit per cycle, into architectural HI/LO registers. It uses a start/busy/done handshake so the pipeline can stall on reads of HI/LO.

## Interface
- `WIDTH`, 32: operand width and width of each of HI and LO; must be ≥ 4.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request an operation; sampled only in IDLE.
- `op` in 2: operation selector (see package constants); sampled with `start`.
- `a` in WIDTH: multiplicand / dividend; sampled with `start`.
- `b` in WIDTH: multiplier / divisor; sampled with `start`.
- `flush` in 1: abort the in-flight operation.
- `mthi`, `mtlo` in 1: direct write of HI / LO from `a`.
- `busy` out 1: operation in flight; reset 0.
- `done` out 1: one-cycle pulse, HI/LO hold the new result; reset 0.
- `hi` out WIDTH: HI register, reset 0.
- `lo` out WIDTH: LO register, reset 0.

## Operation
- Op codes: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- Multiply: {hi,lo} = a × b, full 2·WIDTH-bit product.
- Divide: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = a. Never traps.
- Signed overflow (a = MIN, b = −1): lo = MIN, hi = 0.
- Signed ops run on magnitudes; the sign is corrected in FIX.
- FSM states: IDLE, CALC, FIX.
  - IDLE→CALC on `start`; operands latched and the step counter is loaded with WIDTH.
  - CALC runs one shift-add or restoring-subtract step per cycle and decrements the counter; CALC→FIX when the counter reaches 0.
  - FIX applies sign correction, writes hi/lo, and goes to IDLE. `done` rises the following cycle.
- `start` while busy: ignored, no queuing.
- `flush` has priority over all other inputs except reset. Any state→IDLE next cycle; hi/lo unchanged; no `done`. `flush` in IDLE has no effect.
- `mthi`/`mtlo`: honoured only in IDLE, ignored while busy.
  - If `start` and `mthi`/`mtlo` occur in the same cycle, the write lands and the operation starts; the operation's result later overwrites it.
  - `mthi` and `mtlo` together write `a` into both registers.
- Reset mid-operation: FSM→IDLE, hi/lo→0, busy/done→0.

## Timing
- `start` sampled at edge 0.
- `busy` is high for cycles 1 through WIDTH+1 (WIDTH CALC cycles plus 1 FIX cycle).
- hi/lo update at the edge that ends FIX.
- `done` is high in cycle WIDTH+2 for exactly one cycle; `busy` is already 0 in that cycle.
- A new `start` is accepted in the same cycle `done` is high (back-to-back issue every WIDTH+2 cycles).
- `mthi`/`mtlo` are visible on hi/lo one cycle after being sampled.
- No combinational path from any input to any output.

## Configuration
- `MULDIV_SIGNED_EN` defined: MULT and DIV are signed as specified, with FIX performing sign correction.
- `MULDIV_SIGNED_EN` undefined: MULT/DIV behave identically to MULTU/DIVU. FIX is still one cycle (latency unchanged), the sign logic is removed, and the signed-overflow rule does not apply.

## Structure
- Shared package `muldiv_pkg`: op-code constants `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, and the state encodings `MD_IDLE`, `MD_CALC`, `MD_FIX`.
- One natural sub-module, `muldiv_step`: the combinational single-iteration datapath (conditional add for multiply, trial subtract with restore for divide) on the WIDTH+1-bit partial register.
- Counter, FSM, and the HI/LO registers stay in `muldiv_unit`.

## Test plan
- WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; `busy` high for cycles 1–33.
- MULT a=−7, b=3 (signed build) → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- Start DIVU 100/7, assert `flush` at cycle 10 → `busy` falls at cycle 11, no `done`, hi/lo keep prior values. A `start` asserted mid-operation is ignored.
- `mtlo` a=0x1234 in IDLE → lo=0x1234 next cycle. `mthi` while busy → hi unchanged. Issue a second `start` in the `done` cycle → second `done` exactly 34 cycles later.
- Deassert `rst_n` at cycle 15 of a MULT → hi=lo=0, busy=done=0 next cycle. Build without `MULDIV_SIGNED_EN`: MULT a=−1, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
